// File: rtl/vin_pkg.sv
// Shared definitions for the LVDS video input front end.
// Holds the lock FSM states, lane bit positions and the 2x2 Bayer dither matrix.
// No logic of its own; imported by every file in the block.
package vin_pkg;

    localparam int LANE_BITS = 21;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } vin_state_t;

    // Colour field positions inside one 21-bit channel slice
    localparam int R_HI   = 19;
    localparam int R_LO   = 14;
    localparam int G_HI   = 11;
    localparam int G_LO   = 7;
    localparam int G_BIT0 = 20;
    localparam int B_HI   = 3;
    localparam int B_LO   = 0;
    localparam int B_BIT1 = 13;
    localparam int B_BIT0 = 12;

    // Sync positions inside the sync-carrying channel slice
    localparam int HS_BIT = 4;
    localparam int VS_BIT = 5;
    localparam int DE_BIT = 6;

    // 2x2 Bayer thresholds, 2 bits each, indexed by {phase_y, phase_x}:
    // (0,0)=0 (0,1)=2 (1,0)=3 (1,1)=1
    localparam logic [7:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

    // Threshold for the given phase, scaled onto the bits that truncation drops
    function automatic logic [5:0] bayer_thr(input logic ph_y, input logic ph_x, input int y_bits);
        logic [5:0] t;
        int         idx;
        idx = 2 * int'({ph_y, ph_x});
        t   = {4'd0, BAYER[idx +: 2]};
        if (6 - y_bits >= 2)
            bayer_thr = t << (6 - y_bits - 2);
        else
            bayer_thr = t >> (2 - (6 - y_bits));
    endfunction

endpackage

// File: rtl/vin_rgb2y.sv
// Unpacks RGB666 from one channel slice and converts it to truncated luma.
// Latency: combinational (0 clocks); the parent registers the result.
// Backpressure: none, pure function of its inputs.
module vin_rgb2y
    import vin_pkg::*;
#(
    parameter int Y_BITS = 4
) (
    input  logic [LANE_BITS-1:0] d,
    input  logic                 ph_x,
    input  logic                 ph_y,
    output logic [Y_BITS-1:0]    y
);

    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic [7:0] sum;
    logic [5:0] y6;
    logic [5:0] ys;
    logic       unused_in;

    assign r   = d[R_HI:R_LO];
    assign g   = {d[G_HI:G_LO], d[G_BIT0]};
    assign b   = {d[B_HI:B_LO], d[B_BIT1:B_BIT0]};

    // r + 2g + b peaks at 252, so 8 bits never overflow
    assign sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    assign y6  = sum[7:2];

`ifdef VIN_DITHER_EN
    logic [6:0] yd;
    assign yd        = {1'b0, y6} + {1'b0, bayer_thr(ph_y, ph_x, Y_BITS)};
    assign ys        = yd[6] ? 6'd63 : yd[5:0];
    assign unused_in = ^d[DE_BIT:HS_BIT];
`else
    assign ys        = y6;
    assign unused_in = ^{ph_x, ph_y, d[DE_BIT:HS_BIT]};
`endif

    assign y = ys[5 -: Y_BITS];

endmodule

// File: rtl/vin_lvds_frontend.sv
// Unpacks deserialised LVDS words to luma and qualifies syncs with a frame-lock FSM.
// Latency: 2 clocks din -> v_pixel/v_hsync/v_de/v_vsync; optional dither via VIN_DITHER_EN.
// Backpressure: none; streaming input, vsync masked until the frame geometry is stable.
module vin_lvds_frontend
    import vin_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int Y_BITS         = 4,
    parameter int SKIP_FRAMES    = 5,
    parameter int SYNC_CH        = 1,
    parameter int TIMEOUT_CYCLES = 2**22,
    parameter int DIM_W          = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANE_BITS*CHANNELS-1:0] din,
    output logic                          v_pclk,
    output logic                          v_vsync,
    output logic                          v_hsync,
    output logic                          v_de,
    output logic [Y_BITS*CHANNELS-1:0]    v_pixel,
    output logic                          locked,
    output logic [DIM_W-1:0]              h_active,
    output logic [DIM_W-1:0]              v_active
);

    localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIM_W-1:0] DIM_MAX  = '1;
    localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);
    localparam logic [3:0]       SKIP_N   = 4'(SKIP_FRAMES);

    logic [LANE_BITS*CHANNELS-1:0] din_q;
    logic [Y_BITS*CHANNELS-1:0]    y_all;
    logic                          hs1, vs1, de1;
    logic                          vs_q;
    logic                          vs_rise, de_rise;
    logic                          xph_cur, yph_cur;

    vin_state_t       state, state_nxt;
    logic [3:0]       fcnt, fcnt_nxt;
    logic             vsync_en, en_nxt;
    logic [DIM_W-1:0] h_nxt, v_nxt;
    logic [DIM_W-1:0] hrun, hrun_nxt;
    logic [DIM_W-1:0] vcnt, vcnt_nxt;
    logic [TO_W-1:0]  tcnt;
    logic             timeout;

    assign v_pclk = clk;
    assign locked = (state == LOCKED);

    // Stage 1: capture the raw deserialised word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) din_q <= '0;
        else      din_q <= din;
    end

    assign hs1     = din_q[SYNC_CH*LANE_BITS + HS_BIT];
    assign vs1     = din_q[SYNC_CH*LANE_BITS + VS_BIT];
    assign de1     = din_q[SYNC_CH*LANE_BITS + DE_BIT];
    assign vs_rise = vs1 & ~vs_q;
    assign de_rise = de1 & ~v_de;

`ifdef VIN_DITHER_EN
    logic xph, yph, hs_rise;
    assign hs_rise = hs1 & ~v_hsync;
    assign xph_cur = hs1 ? 1'b0 : xph;
    assign yph_cur = vs1 ? 1'b0 : (hs_rise ? ~yph : yph);

    // Dither phases: x alternates every clock from hsync, y toggles per line from vsync
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xph <= 1'b0;
            yph <= 1'b0;
        end else begin
            xph <= ~xph_cur;
            yph <= yph_cur;
        end
    end
`else
    assign xph_cur = 1'b0;
    assign yph_cur = 1'b0;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic ph_x;
        assign ph_x = (c % 2 == 1) ? ~xph_cur : xph_cur;

        vin_rgb2y #(.Y_BITS(Y_BITS)) u_rgb2y (
            .d    (din_q[c*LANE_BITS +: LANE_BITS]),
            .ph_x (ph_x),
            .ph_y (yph_cur),
            .y    (y_all[(CHANNELS-1-c)*Y_BITS +: Y_BITS])
        );
    end

    // Stage 2: register luma and syncs; vsync passes only for pulses that start while enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_pixel <= '0;
            v_hsync <= 1'b0;
            v_de    <= 1'b0;
            vs_q    <= 1'b0;
            v_vsync <= 1'b0;
        end else begin
            v_pixel <= y_all;
            v_hsync <= hs1;
            v_de    <= de1;
            vs_q    <= vs1;
            v_vsync <= vs1 & en_nxt & (vs_rise ? vsync_en : v_vsync);
        end
    end

    // Geometry counters: de clocks of the current line and de rises of the current frame, saturating
    always_comb begin
        hrun_nxt = hrun;
        vcnt_nxt = vcnt;
        if (de_rise)
            hrun_nxt = DIM_ONE;
        else if (de1 && hrun != DIM_MAX)
            hrun_nxt = hrun + DIM_ONE;
        if (de_rise && vcnt != DIM_MAX)
            vcnt_nxt = vcnt + DIM_ONE;
    end

    assign timeout = (state != IDLE) && (tcnt == TO_LAST);

    // Lock FSM: timeout has priority over a coincident vsync rise
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        en_nxt    = vsync_en;
        h_nxt     = h_active;
        v_nxt     = v_active;
        if (timeout) begin
            state_nxt = IDLE;
            fcnt_nxt  = 4'd0;
            en_nxt    = 1'b0;
        end else if (vs_rise) begin
            case (state)
                IDLE: begin
                    if (SKIP_N == 4'd0) begin
                        state_nxt = MEASURE;
                    end else begin
                        state_nxt = SKIP;
                        fcnt_nxt  = 4'd1;
                    end
                end
                SKIP: begin
                    if (fcnt >= SKIP_N) state_nxt = MEASURE;
                    else                fcnt_nxt  = fcnt + 4'd1;
                end
                MEASURE: begin
                    h_nxt     = hrun_nxt;
                    v_nxt     = vcnt_nxt;
                    state_nxt = LOCKED;
                    en_nxt    = 1'b1;
                end
                LOCKED: begin
                    if (hrun_nxt != h_active || vcnt_nxt != v_active) begin
                        h_nxt     = hrun_nxt;
                        v_nxt     = vcnt_nxt;
                        state_nxt = MEASURE;
                        en_nxt    = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM and counter state; the line count restarts on each vsync rise after counting a coincident de rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fcnt     <= 4'd0;
            vsync_en <= 1'b0;
            h_active <= '0;
            v_active <= '0;
            hrun     <= '0;
            vcnt     <= '0;
            tcnt     <= '0;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            vsync_en <= en_nxt;
            h_active <= h_nxt;
            v_active <= v_nxt;
            hrun     <= hrun_nxt;
            vcnt     <= vs_rise ? '0 : vcnt_nxt;
            if (state == IDLE || vs_rise)
                tcnt <= '0;
            else if (tcnt != TO_LAST)
                tcnt <= tcnt + 1'b1;
        end
    end

endmodule
